// File: rtl/sram_arb_rr.sv
// ---------------------------------------------------------------------------
// sram_arb_rr
//
// Purpose:
//    Shares one asynchronous SRAM between NUM_MASTERS Avalon-MM style slave
//    ports. An idle cycle with at least one request accepts exactly one
//    master. The next cycle is the SRAM access cycle with registered strobes.
//    Read data is captured at the edge that ends the access. It is returned
//    on the shared m_readdata bus, with a one-hot m_readdatavalid strobe that
//    tells the masters which of them owns the data.
//
// Ports:
//    clock            single clock, all state on the rising edge
//    reset_n          asynchronous active-low reset
//    m_address        per-master word address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//    m_byteenable     per-master byte enables (active high)
//    m_read           per-master read request
//    m_write          per-master write request (wins over read when both set)
//    m_writedata      per-master write data
//    m_waitrequest    per-master stall, low only in the cycle of acceptance
//    m_readdata       shared registered read data, holds until next capture
//    m_readdatavalid  one-hot read-return strobe, one cycle wide
//    sram_address     registered SRAM address, holds between accesses
//    sram_data        bidirectional SRAM data bus
//    sram_ce_n        registered chip enable (active low)
//    sram_oe_n        registered output enable (active low)
//    sram_we_n        registered write enable (active low)
//    sram_be_n        registered byte enables (active low)
// ---------------------------------------------------------------------------
module sram_arb_rr #(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int BE_WIDTH    = DATA_WIDTH / 8,
   parameter int NUM_MASTERS = 2,
   parameter int RR_EN       = 1
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
   input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable,
   input  logic [NUM_MASTERS-1:0]            m_read,
   input  logic [NUM_MASTERS-1:0]            m_write,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
   output logic [NUM_MASTERS-1:0]            m_waitrequest,
   output logic [DATA_WIDTH-1:0]             m_readdata,
   output logic [NUM_MASTERS-1:0]            m_readdatavalid,
   output logic [ADDR_WIDTH-1:0]             sram_address,
   inout  wire  [DATA_WIDTH-1:0]             sram_data,
   output logic                              sram_ce_n,
   output logic                              sram_oe_n,
   output logic                              sram_we_n,
   output logic [BE_WIDTH-1:0]               sram_be_n
);

   // Width of a master index; a single master still needs one bit.
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [NUM_MASTERS-1:0]   request;
   logic                     any_req;
   logic                     accept;
   logic [IDX_W-1:0]         winner;
   logic [NUM_MASTERS-1:0]   grant;
   logic [IDX_W-1:0]         last_grant_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic                     is_write_q;
   logic [NUM_MASTERS-1:0]   owner_q;

   // Picks the winning master. In round-robin mode the search starts just
   // above the previous winner and wraps, so every requester is reached
   // within NUM_MASTERS accepts. In fixed mode the lowest index always wins.
   function automatic logic [IDX_W-1:0] pick_winner(
      input logic [NUM_MASTERS-1:0] req,
      input logic [IDX_W-1:0]       last
   );
      logic [IDX_W-1:0] slot;
      logic             found;
      pick_winner = '0;
      found       = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (RR_EN != 0) begin
            slot = IDX_W'((int'(last) + 1 + k) % NUM_MASTERS);
         end else begin
            slot = IDX_W'(k);
         end
         if (!found && req[slot]) begin
            found       = 1'b1;
            pick_winner = slot;
         end
      end
   endfunction

   // Request decode and arbitration. Acceptance is gated by reset_n, so no
   // master sees a low waitrequest while reset is held. It is also limited
   // to IDLE, which makes the SRAM cycle that follows exclusive.
   always_comb begin
      request = m_read | m_write;
      any_req = |request;
      winner  = pick_winner(request, last_grant_q);
      accept  = reset_n && (state_q == IDLE) && any_req;
      grant   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         grant[i] = accept && (winner == IDX_W'(i));
      end
      m_waitrequest = ~grant;
   end

   // Two-state sequencer: an accepted request always gets exactly one
   // ACCESS cycle, then control returns to IDLE. The next accept can
   // therefore overlap the read-return cycle of the previous access.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The round-robin pointer starts at the top index so that master 0 is
   // served first after reset. It only moves when a request is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      end else if (accept) begin
         last_grant_q <= winner;
      end
   end

   // SRAM side registers. On accept, the winner's request is loaded straight
   // into the pin registers, so the strobes are low for the whole ACCESS
   // cycle. In every other cycle the strobes and byte enables go back to
   // inactive. The address keeps its last value so that the address pins do
   // not toggle needlessly. A write with read also set is treated as a pure
   // write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sram_address <= '0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_be_n    <= '1;
         wdata_q      <= '0;
         is_write_q   <= 1'b0;
         owner_q      <= '0;
      end else if (accept) begin
         sram_address <= m_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
         sram_be_n    <= ~m_byteenable[winner*BE_WIDTH +: BE_WIDTH];
         wdata_q      <= m_writedata[winner*DATA_WIDTH +: DATA_WIDTH];
         is_write_q   <= m_write[winner];
         owner_q      <= grant;
         sram_ce_n    <= 1'b0;
         sram_oe_n    <= m_write[winner];
         sram_we_n    <= ~m_write[winner];
      end else begin
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_be_n    <= '1;
      end
   end

   // Read return. The SRAM output settles during ACCESS and is sampled at
   // the edge that ends it. The valid strobe is cleared every other cycle, so
   // it is exactly one cycle wide. An async reset during ACCESS clears it
   // before it can fire.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_readdata      <= '0;
         m_readdatavalid <= '0;
      end else begin
         m_readdatavalid <= '0;
         if (state_q == ACCESS && !is_write_q) begin
            m_readdata      <= sram_data;
            m_readdatavalid <= owner_q;
         end
      end
   end

   // The data bus is driven only while the write strobe is active. This
   // keeps it high-Z in reset and during reads.
   assign sram_data = (!sram_we_n) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
